alpu_wb_buffer: RTL
===================

# alpu_wb_buffer

Result writeback buffer directly downstream of the ALPU execution unit. Captures each ALPU result (`out_o`/`cout_o`) together with its destination register tag into an in-order FIFO. Drains it to the register file over a valid/ready handshake and maintains the architectural carry flag. Also provides youngest-match operand forwarding of still-buffered results back to the issue side.

## Interface
Parameters:
- `REG_WIDTH`, 4, data width; matches the ALPU.
- `DEPTH`, 4, number of FIFO entries; power of two, ≥2.
- `ADDR_WIDTH`, 3, destination register index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous clear of all buffered entries.
- `in_valid_i`  in  1  ALPU result valid this cycle.
- `in_ready_o`  out  1  buffer can accept a result.
- `in_dest_i`  in  ADDR_WIDTH  destination register index.
- `in_data_i`  in  REG_WIDTH  ALPU `out_o`.
- `in_cout_i`  in  1  ALPU `cout_o`.
- `in_wr_carry_i`  in  1  the instruction updates the carry flag.
- `wb_valid_o`  out  1  head entry is presented.
- `wb_ready_i`  in  1  register file accepts the head entry.
- `wb_dest_o`  out  ADDR_WIDTH  head destination.
- `wb_data_o`  out  REG_WIDTH  head data.
- `carry_flag_o`  out  1  architectural carry flag.
- `count_o`  out  $clog2(DEPTH+1)  occupied entries.
- `fwd_addr_i`  in  ADDR_WIDTH  forwarding query register index.
- `fwd_hit_o`  out  1  a buffered entry targets `fwd_addr_i`.
- `fwd_data_o`  out  REG_WIDTH  data of the youngest matching entry.

## Operation
- Push occurs when `in_valid_i && in_ready_o`. The entry is written at the write pointer, and the write pointer increments.
- Pop occurs when `wb_valid_o && wb_ready_i`. The read pointer increments. If the popped entry has `wr_carry` set, `carry_flag_o` takes that entry's `cout` on the same edge.
- `in_ready_o = (count < DEPTH)`. When the buffer is full, a same-cycle pop does not raise ready, so there is no combinational ready path from `wb_ready_i`.
- `wb_valid_o = (count != 0)`. The `wb_*` outputs are driven from the head entry. `wb_dest_o` and `wb_data_o` are 0 when empty.
- Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged and moves both pointers.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from DEPTH-1 to 0.
- Push while full and pop while empty are impossible by handshake. Entries and pointers stay unchanged.
- `flush_i` has priority over push and pop in the same cycle. It zeroes both pointers and count and discards all entries, including a same-cycle push. `carry_flag_o` is **not** changed by a flush, even if a pop was also requested.
- Forwarding is combinational over valid entries only:
  - The search runs from youngest (write pointer − 1) to oldest (head).
  - The first entry whose dest equals `fwd_addr_i` wins.
  - A same-cycle incoming push is not considered.
  - If there is no match, or the buffer is empty, `fwd_hit_o` = 0 and `fwd_data_o` = 0.

## Timing
- Latency is 1 cycle from push edge to `wb_valid_o`. There is no empty-buffer bypass.
- Maximum throughput is one push and one pop per cycle.
- `count_o`, `carry_flag_o` and the pointers are registered. `in_ready_o`, `wb_valid_o` and the `wb_*` outputs decode registered state only.
- The `fwd_*` outputs are combinational from `fwd_addr_i` and the registered entries.
- Reset (asynchronous, any time, including mid-drain) sets:
  - pointers to 0;
  - `count_o` = 0;
  - `carry_flag_o` = 0;
  - `wb_valid_o` = 0, `wb_dest_o` = 0, `wb_data_o` = 0;
  - `in_ready_o` = 1;
  - `fwd_hit_o` = 0, `fwd_data_o` = 0.
- The first push is accepted on the first rising edge after `reset_n` deasserts.

## Structure
- Package `alpu_wb_pkg` holds:
  - typedef `wb_entry_t`, a packed struct {dest, data, cout, wr_carry}, parameterised by the widths via package parameters;
  - localparams for pointer width and count width.
- Sub-module `alpu_wb_fifo_ctrl` holds the pointer, count, full/empty and flush-priority logic.
- The top level holds the entry storage array, the carry flag register and the forwarding priority search.

## Test plan
All scenarios use `REG_WIDTH=4`, `DEPTH=4`, `ADDR_WIDTH=3`.
- **Basic pass-through:** push {dest 3, data 0xA, cout 1, wr_carry 1} with `wb_ready_i`=1.
  - Next cycle: `wb_valid_o`=1, `wb_dest_o`=3, `wb_data_o`=0xA.
  - Edge after that: `carry_flag_o`=1, `count_o`=0.
- **Fill and backpressure:** hold `wb_ready_i`=0 and push 0x1..0x4.
  - `count_o`=4 and `in_ready_o`=0.
  - A 5th push is not accepted.
  - Release `wb_ready_i`: data drains in order 1,2,3,4.
- **Wrap-around:** run 10 pushes with continuous simultaneous pops.
  - Data emerges in order with no loss.
  - `count_o` stays ≤1.
- **Forwarding:** buffer holds dest 2 = 0x5 (older) and dest 2 = 0x9 (younger). Query `fwd_addr_i`=2.
  - `fwd_hit_o`=1, `fwd_data_o`=0x9.
  - Query 6: `fwd_hit_o`=0, `fwd_data_o`=0.
- **Flush priority:** with 3 entries, assert `flush_i` together with push and pop, the popped entry having wr_carry=1 and cout=1.
  - Next cycle: `count_o`=0, `wb_valid_o`=0.
  - `carry_flag_o` is unchanged.
- **Reset mid-operation:** with 2 entries and `carry_flag_o`=1, pulse `reset_n` low between clock edges.
  - All outputs go to their reset values immediately.
  - After release: `in_ready_o`=1 and a fresh push is accepted.

Source files
------------

// File: rtl/alpu_wb_pkg.sv
// Shared widths and the buffered-entry layout for the ALPU writeback buffer.
package alpu_wb_pkg;

  localparam int REG_WIDTH  = 4;
  localparam int DEPTH      = 4;
  localparam int ADDR_WIDTH = 3;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [REG_WIDTH-1:0]  data;
    logic                  cout;
    logic                  wr_carry;
  } wb_entry_t;

endpackage

// File: rtl/alpu_wb_buffer_if.sv
// Bus bundle between the ALPU/issue side (master) and the writeback buffer (slave).
interface alpu_wb_buffer_if #(
  parameter int REG_WIDTH  = 4,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Valid must not depend on ready; ready here decodes registered state only.
  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [ADDR_WIDTH-1:0] in_dest_i;
  logic [REG_WIDTH-1:0]  in_data_i;
  logic                  in_cout_i;
  logic                  in_wr_carry_i;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [ADDR_WIDTH-1:0] wb_dest_o;
  logic [REG_WIDTH-1:0]  wb_data_o;
  logic                  carry_flag_o;
  logic [CNT_W-1:0]      count_o;
  logic [ADDR_WIDTH-1:0] fwd_addr_i;
  logic                  fwd_hit_o;
  logic [REG_WIDTH-1:0]  fwd_data_o;

  modport master (
    output flush_i, in_valid_i, in_dest_i, in_data_i, in_cout_i, in_wr_carry_i,
           wb_ready_i, fwd_addr_i,
    input  in_ready_o, wb_valid_o, wb_dest_o, wb_data_o, carry_flag_o, count_o,
           fwd_hit_o, fwd_data_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_dest_i, in_data_i, in_cout_i, in_wr_carry_i,
           wb_ready_i, fwd_addr_i,
    output in_ready_o, wb_valid_o, wb_dest_o, wb_data_o, carry_flag_o, count_o,
           fwd_hit_o, fwd_data_o
  );

endinterface

// File: rtl/alpu_wb_fifo_ctrl.sv
// Pointer/count bookkeeping for the writeback FIFO; flush overrides push and pop.
import alpu_wb_pkg::*;

module alpu_wb_fifo_ctrl #(
  parameter int DEPTH = alpu_wb_pkg::DEPTH,
  parameter int PTR_W = alpu_wb_pkg::PTR_W,
  parameter int CNT_W = alpu_wb_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push_req,
  input  logic             pop_req,
  output logic             push_en,
  output logic             pop_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Qualified strobes already exclude flush, so storage and carry never see a flushed op.
  assign push_en = push_req && !full && !flush;
  assign pop_en  = pop_req && !empty && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alpu_wb_buffer.sv
// In-order writeback buffer behind the ALPU: entry storage, carry flag, youngest-match forwarding.
import alpu_wb_pkg::*;

module alpu_wb_buffer #(
  parameter int REG_WIDTH  = alpu_wb_pkg::REG_WIDTH,
  parameter int DEPTH      = alpu_wb_pkg::DEPTH,
  parameter int ADDR_WIDTH = alpu_wb_pkg::ADDR_WIDTH
) (
  input logic              clk,
  input logic              reset_n,
  alpu_wb_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push_en;
  logic             pop_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             carry_flag;
  wb_entry_t        mem [DEPTH];
  wb_entry_t        head;

  alpu_wb_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (bus.flush_i),
    .push_req (bus.in_valid_i),
    .pop_req  (bus.wb_ready_i),
    .push_en  (push_en),
    .pop_en   (pop_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_en) begin
      mem[wr_ptr] <= '{dest: bus.in_dest_i, data: bus.in_data_i,
                       cout: bus.in_cout_i, wr_carry: bus.in_wr_carry_i};
    end
  end

  assign head = mem[rd_ptr];

  // Carry is architectural: it changes only when a carry-writing entry actually retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry_flag <= 1'b0;
    end else if (pop_en && head.wr_carry) begin
      carry_flag <= head.cout;
    end
  end

  assign bus.in_ready_o   = !full;
  assign bus.wb_valid_o   = !empty;
  assign bus.wb_dest_o    = empty ? '0 : head.dest;
  assign bus.wb_data_o    = empty ? '0 : head.data;
  assign bus.carry_flag_o = carry_flag;
  assign bus.count_o      = count;

  // Walk oldest to youngest over valid slots; a later match overwrites, so the youngest wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    bus.fwd_hit_o  = 1'b0;
    bus.fwd_data_o = '0;
    idx            = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (mem[idx].dest == bus.fwd_addr_i)) begin
        bus.fwd_hit_o  = 1'b1;
        bus.fwd_data_o = mem[idx].data;
      end
    end
  end

endmodule
